// File: rtl/ieee_handshake_ctrl.sv
// IEEE-488 style three-wire handshake controller: a talker FSM that sources bytes onto the bus
// and a listener FSM that accepts them, sharing synchronized bus inputs and registered bus drives.
module ieee_handshake_ctrl #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic       phi2,
    input  logic       reset,
    input  logic       talk,
    input  logic       listen,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_eoi,
    output logic       tx_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_eoi,
    input  logic       rx_ack,
    input  logic [7:0] dio_in,
    input  logic       dav_in,
    input  logic       nrfd_in,
    input  logic       ndac_in,
    input  logic       eoi_in,
    output logic [7:0] dio_out,
    output logic       dio_oe,
    output logic       dav_out,
    output logic       nrfd_out,
    output logic       ndac_out,
    output logic       eoi_out,
    output logic       timeout,
    output logic       no_listener,
    output logic       busy
);

    typedef enum logic [2:0] {
        T_IDLE     = 3'd0,
        T_WAIT_RFD = 3'd1,
        T_SETTLE   = 3'd2,
        T_DAV      = 3'd3,
        T_RELEASE  = 3'd4
    } t_state_e;

    typedef enum logic [1:0] {
        L_IDLE   = 2'd0,
        L_READY  = 2'd1,
        L_ACCEPT = 2'd2,
        L_DONE   = 2'd3
    } l_state_e;

    localparam logic [9:0] SETTLE_LAST = 10'(SETTLE - 1);
    localparam logic [9:0] TMO_LAST    = 10'(TIMEOUT - 1);

    t_state_e   t_q, t_d;
    l_state_e   l_q, l_d;
    logic [9:0] cnt_q, cnt_d;
    logic [11:0] sync1_q, sync2_q;
    logic [7:0] hold_q, hold_d;
    logic       hold_eoi_q, hold_eoi_d;
    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_eoi_q, rx_eoi_d;
    logic       tx_ready_q, tx_ready_d;
    logic [7:0] dio_out_q, dio_out_d;
    logic       dio_oe_q, dio_oe_d;
    logic       dav_out_q, dav_out_d;
    logic       eoi_out_q, eoi_out_d;
    logic       nrfd_out_q, nrfd_out_d;
    logic       ndac_out_q, ndac_out_d;
    logic       timeout_q, timeout_d;
    logic       no_listener_q, no_listener_d;
    logic       busy_q, busy_d;

    logic       dav_s, nrfd_s, ndac_s, eoi_s, lst_act_s, tmo_hit_s;
    logic [7:0] dio_s;

    assign dav_s     = sync2_q[11];
    assign nrfd_s    = sync2_q[10];
    assign ndac_s    = sync2_q[9];
    assign eoi_s     = sync2_q[8];
    assign dio_s     = sync2_q[7:0];
    assign lst_act_s = listen & ~talk;
    assign tmo_hit_s = (cnt_q == TMO_LAST);

    // Talker next state; a wait that reaches the timeout or loses talk falls back to idle
    always_comb begin
        t_d           = t_q;
        hold_d        = hold_q;
        hold_eoi_d    = hold_eoi_q;
        timeout_d     = 1'b0;
        no_listener_d = 1'b0;
        case (t_q)
            T_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    hold_d     = tx_data;
                    hold_eoi_d = tx_eoi;
                    t_d        = T_WAIT_RFD;
                end else begin
                    t_d = T_IDLE;
                end
            end
            T_WAIT_RFD: begin
                if (!talk) begin
                    t_d = T_IDLE;
                end else if (!nrfd_s && ndac_s) begin
                    t_d = T_SETTLE;
                end else if (!nrfd_s && !ndac_s) begin
                    no_listener_d = 1'b1;
                    t_d           = T_IDLE;
                end else if (tmo_hit_s) begin
                    timeout_d = 1'b1;
                    t_d       = T_IDLE;
                end else begin
                    t_d = T_WAIT_RFD;
                end
            end
            T_SETTLE: begin
                if (!talk) begin
                    t_d = T_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    t_d = T_DAV;
                end else begin
                    t_d = T_SETTLE;
                end
            end
            T_DAV: begin
                if (!talk) begin
                    t_d = T_IDLE;
                end else if (!ndac_s) begin
                    t_d = T_RELEASE;
                end else if (tmo_hit_s) begin
                    timeout_d = 1'b1;
                    t_d       = T_IDLE;
                end else begin
                    t_d = T_DAV;
                end
            end
            T_RELEASE: begin
                if (!talk) begin
                    t_d = T_IDLE;
                end else if (ndac_s) begin
                    t_d = T_IDLE;
                end else if (tmo_hit_s) begin
                    timeout_d = 1'b1;
                    t_d       = T_IDLE;
                end else begin
                    t_d = T_RELEASE;
                end
            end
            default: begin
                t_d = T_IDLE;
            end
        endcase
        if ((t_d != t_q) || (t_q == T_IDLE)) begin
            cnt_d = 10'd0;
        end else begin
            cnt_d = cnt_q + 10'd1;
        end
    end

    // Listener next state; an unacknowledged byte survives a mode drop
    always_comb begin
        l_d       = l_q;
        rx_data_d = rx_data_q;
        rx_eoi_d  = rx_eoi_q;
        if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
        case (l_q)
            L_IDLE: begin
                if (lst_act_s && !rx_valid_q) begin
                    l_d = L_READY;
                end else begin
                    l_d = L_IDLE;
                end
            end
            L_READY: begin
                if (!lst_act_s) begin
                    l_d = L_IDLE;
                end else if (dav_s) begin
                    rx_data_d  = dio_s;
                    rx_eoi_d   = eoi_s;
                    rx_valid_d = 1'b1;
                    l_d        = L_ACCEPT;
                end else begin
                    l_d = L_READY;
                end
            end
            L_ACCEPT: begin
                if (!lst_act_s) begin
                    l_d = L_IDLE;
                end else if (rx_ack && rx_valid_q) begin
                    l_d = L_DONE;
                end else begin
                    l_d = L_ACCEPT;
                end
            end
            L_DONE: begin
                if (!lst_act_s || !dav_s) begin
                    l_d = L_IDLE;
                end else begin
                    l_d = L_DONE;
                end
            end
            default: begin
                l_d = L_IDLE;
            end
        endcase
    end

    // Bus drives decoded from the next state so every output is a flop
    always_comb begin
        dio_oe_d   = (t_d == T_WAIT_RFD) || (t_d == T_SETTLE) || (t_d == T_DAV) || (t_d == T_RELEASE);
        dio_out_d  = dio_oe_d ? hold_d : 8'h00;
        dav_out_d  = (t_d == T_DAV);
        eoi_out_d  = ((t_d == T_SETTLE) || (t_d == T_DAV)) ? hold_eoi_d : 1'b0;
        tx_ready_d = talk && (t_d == T_IDLE);
        busy_d     = (t_d != T_IDLE) || (l_d != L_IDLE);
        case (l_d)
            L_IDLE: begin
                nrfd_out_d = lst_act_s;
                ndac_out_d = lst_act_s;
            end
            L_READY: begin
                nrfd_out_d = 1'b0;
                ndac_out_d = 1'b1;
            end
            L_ACCEPT: begin
                nrfd_out_d = 1'b1;
                ndac_out_d = 1'b1;
            end
            L_DONE: begin
                nrfd_out_d = 1'b1;
                ndac_out_d = 1'b0;
            end
            default: begin
                nrfd_out_d = 1'b0;
                ndac_out_d = 1'b0;
            end
        endcase
    end

    // State, synchronizer and output registers
    always_ff @(posedge phi2) begin
        if (reset) begin
            t_q           <= T_IDLE;
            l_q           <= L_IDLE;
            cnt_q         <= 10'd0;
            sync1_q       <= 12'd0;
            sync2_q       <= 12'd0;
            hold_q        <= 8'h00;
            hold_eoi_q    <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_eoi_q      <= 1'b0;
            tx_ready_q    <= 1'b0;
            dio_out_q     <= 8'h00;
            dio_oe_q      <= 1'b0;
            dav_out_q     <= 1'b0;
            eoi_out_q     <= 1'b0;
            nrfd_out_q    <= 1'b0;
            ndac_out_q    <= 1'b0;
            timeout_q     <= 1'b0;
            no_listener_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            t_q           <= t_d;
            l_q           <= l_d;
            cnt_q         <= cnt_d;
            sync1_q       <= {dav_in, nrfd_in, ndac_in, eoi_in, dio_in};
            sync2_q       <= sync1_q;
            hold_q        <= hold_d;
            hold_eoi_q    <= hold_eoi_d;
            rx_valid_q    <= rx_valid_d;
            rx_data_q     <= rx_data_d;
            rx_eoi_q      <= rx_eoi_d;
            tx_ready_q    <= tx_ready_d;
            dio_out_q     <= dio_out_d;
            dio_oe_q      <= dio_oe_d;
            dav_out_q     <= dav_out_d;
            eoi_out_q     <= eoi_out_d;
            nrfd_out_q    <= nrfd_out_d;
            ndac_out_q    <= ndac_out_d;
            timeout_q     <= timeout_d;
            no_listener_q <= no_listener_d;
            busy_q        <= busy_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign rx_eoi      = rx_eoi_q;
    assign dio_out     = dio_out_q;
    assign dio_oe      = dio_oe_q;
    assign dav_out     = dav_out_q;
    assign eoi_out     = eoi_out_q;
    assign nrfd_out    = nrfd_out_q;
    assign ndac_out    = ndac_out_q;
    assign timeout     = timeout_q;
    assign no_listener = no_listener_q;
    assign busy        = busy_q;

endmodule
